// File: rtl/uart_pkg.sv
// uart_pkg: state encoding and framing constants shared by the UART RX and TX sides.
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction
endpackage

// File: rtl/uart_rx_sampler.sv
// uart_rx_sampler: RX synchroniser, bit-period edge counter and bit sampling.
// UART_RX_MAJORITY_VOTE_EN selects 2-of-3 voting around mid-bit instead of a single sample.
module uart_rx_sampler #(
  parameter int PRE_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rx_in,
  input  logic             active,
  input  logic [PRE_W-1:0] pre,
  output logic             rx_s,
  output logic             sample_stb,
  output logic             sample_bit,
  output logic             bit_end
);
  logic rx_m;
  logic [PRE_W-1:0] edge_cnt, half;
  assign half = pre >> 1;
  assign bit_end = active && edge_cnt == pre - 1'b1;
  // Synchroniser resets to idle-high so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {rx_s, rx_m} <= 2'b11;
    else {rx_s, rx_m} <= {rx_m, rx_in};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) edge_cnt <= '0;
    else edge_cnt <= (!active || bit_end) ? '0 : edge_cnt + 1'b1;
`ifdef UART_RX_MAJORITY_VOTE_EN
  logic v0, v1;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {v0, v1} <= 2'b11;
    else begin
      if (edge_cnt == half - 1'b1) v0 <= rx_s;
      if (edge_cnt == half) v1 <= rx_s;
    end
  assign sample_stb = active && edge_cnt == half + 1'b1;
  assign sample_bit = uart_pkg::maj3(v0, v1, rx_s);
`else
  assign sample_stb = active && edge_cnt == half;
  assign sample_bit = rx_s;
`endif
endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with optional parity and parity/stop error pulses.
// UART_RX_MAJORITY_VOTE_EN (in uart_rx_sampler) enables majority-vote bit sampling.
module uart_rx import uart_pkg::*; #(
  parameter int width = 8,
  parameter int PRE_W = 6
) (
  input  logic             CLK_RX,
  input  logic             RST_RX,
  input  logic             RX_IN,
  input  logic [PRE_W-1:0] PRESCALE,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [width-1:0] P_DATA,
  output logic             DATA_VALID,
  output logic             PAR_ERR,
  output logic             STP_ERR
);
  localparam int BW = $clog2(width + 1);
  localparam logic [BW-1:0] LAST = BW'(width - 1);
  rx_state_t state, next;
  logic rx_s, sample_stb, sample_bit, bit_end;
  logic armed, par_en_q, par_typ_q, par_bad;
  logic start_det, last_bit, stop_smp, stp_bad, par_fail, good;
  logic [PRE_W-1:0] pre_q;
  logic [BW-1:0] bit_cnt;
  logic [width-1:0] shift;
  uart_rx_sampler #(.PRE_W(PRE_W)) u_sampler (
    .clk(CLK_RX), .rst_n(RST_RX), .rx_in(RX_IN), .active(state != IDLE), .pre(pre_q),
    .rx_s(rx_s), .sample_stb(sample_stb), .sample_bit(sample_bit), .bit_end(bit_end)
  );
  always_ff @(posedge CLK_RX or negedge RST_RX)
    if (!RST_RX) state <= IDLE;
    else state <= next;
  always_comb begin
    next = state;
    case (state)
      IDLE:    next = start_det ? START : IDLE;
      START:   next = (sample_stb && sample_bit != START_BIT) ? IDLE : bit_end ? DATA : START;
      DATA:    next = (bit_end && last_bit) ? (par_en_q ? PARITY : STOP) : DATA;
      PARITY:  next = bit_end ? STOP : PARITY;
      STOP:    next = sample_stb ? IDLE : STOP;
      default: next = IDLE;
    endcase
  end
  always_comb begin
    start_det = state == IDLE && armed && rx_s == START_BIT;
    last_bit = bit_cnt == LAST;
    stop_smp = state == STOP && sample_stb;
    stp_bad = stop_smp && sample_bit != STOP_BIT;
    par_fail = stop_smp && par_bad;
    good = stop_smp && !stp_bad && !par_fail;
  end
  always_ff @(posedge CLK_RX or negedge RST_RX)
    if (!RST_RX) begin
      {pre_q, par_en_q, par_typ_q, par_bad, bit_cnt, shift} <= '0;
      {P_DATA, DATA_VALID, PAR_ERR, STP_ERR} <= '0;
      armed <= 1'b1;
    end else begin
      if (start_det) begin
        pre_q <= PRESCALE;
        par_en_q <= PAR_EN;
        par_typ_q <= PAR_TYP;
        par_bad <= 1'b0;
        bit_cnt <= '0;
      end
      if (state == DATA && sample_stb) shift <= {sample_bit, shift[width-1:1]};
      if (state == DATA && bit_end) bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      if (state == PARITY && sample_stb) par_bad <= sample_bit != (^shift ^ par_typ_q);
      // A bad stop disarms start detection so a held-low line (break) cannot restart a frame.
      armed <= stp_bad ? 1'b0 : (rx_s | armed);
      DATA_VALID <= good;
      PAR_ERR <= par_fail;
      STP_ERR <= stp_bad;
      if (good) P_DATA <= shift;
    end
endmodule
